// File: rtl/spi_flash_reader.sv
// SPI mode-0 read master for W25Q16-class flash: shifts out the read opcode and a 24-bit
// address, then clocks in rd_len bytes and presents each one with a single-cycle rd_valid.
module spi_flash_reader #(
    parameter int         CLK_DIV = 2,
    parameter logic [7:0] RD_CMD  = 8'h03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_start,
    input  logic [23:0] rd_addr,
    input  logic [8:0]  rd_len,
    input  logic        spi_miso,
    output logic        spi_clk,
    output logic        cs,
    output logic        spi_mosi,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_busy,
    output logic        rd_done
);

    // state | meaning
    // IDLE  | cs high, waiting for rd_start with a nonzero rd_len
    // SETUP | cs low, SCLK low for CLK_DIV cycles, opcode MSB already on MOSI
    // SHIFT | 32 opcode/address bits out, then 8*rd_len data bits in
    // HOLD  | SCLK parked low for CLK_DIV cycles before cs is released
    // DONE  | cs high, rd_done pulse, back to IDLE
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [12:0]      bits_q, bits_d;
    logic [8:0]       byte_q, byte_d;
    logic [31:0]      sh_q, sh_d;
    logic [6:0]       rx_q, rx_d;
    logic             sclk_d, cs_d, mosi_d, valid_d, busy_d, done_d;
    logic [7:0]       data_d;
    logic             data_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bits_q   <= '0;
            byte_q   <= '0;
            sh_q     <= '0;
            rx_q     <= '0;
            spi_clk  <= 1'b0;
            cs       <= 1'b1;
            spi_mosi <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_busy  <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bits_q   <= bits_d;
            byte_q   <= byte_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            spi_clk  <= sclk_d;
            cs       <= cs_d;
            spi_mosi <= mosi_d;
            rd_data  <= data_d;
            rd_valid <= valid_d;
            rd_busy  <= busy_d;
            rd_done  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bits_d  = bits_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        sclk_d  = spi_clk;
        cs_d    = cs;
        mosi_d  = spi_mosi;
        data_d  = rd_data;
        valid_d = 1'b0;
        busy_d  = rd_busy;
        done_d  = 1'b0;
        // bits_q counts remaining bits down to 0; the last 8*byte_q of them are data bits
        data_bit = ({1'b0, byte_q, 3'b000} > bits_q);

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (rd_start && rd_len != 9'd0) begin
                    state_d = SETUP;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = DIV_LOAD;
                    sh_d    = {RD_CMD, rd_addr};
                    mosi_d  = RD_CMD[7];
                    byte_d  = rd_len;
                    bits_d  = {1'b0, rd_len, 3'b000} + 13'd31;
                end
            end

            SETUP: begin
                if (div_q == '0) begin
                    state_d = SHIFT;
                    div_d   = DIV_LOAD;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else if (!spi_clk) begin
                    sclk_d = 1'b1;
                    div_d  = DIV_LOAD;
                    if (data_bit) begin
                        rx_d = {rx_q[5:0], spi_miso};
                        // remaining count is a multiple of 8 on the last bit of each byte
                        if (bits_q[2:0] == 3'b000) begin
                            data_d  = {rx_q, spi_miso};
                            valid_d = 1'b1;
                            byte_d  = byte_q - 9'd1;
                        end
                    end
                end else begin
                    sclk_d = 1'b0;
                    div_d  = DIV_LOAD;
                    if (bits_q == 13'd0) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bits_d = bits_q - 13'd1;
                        sh_d   = {sh_q[30:0], 1'b0};
                        mosi_d = sh_q[30];
                    end
                end
            end

            HOLD: begin
                if (div_q == '0) begin
                    state_d = DONE;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2 and CLK_DIV=1) talk to a byte-array
// flash model; per-frame observations are compared with values derived from address and length.
`timescale 1ns/1ps
module tb_spi_flash_reader;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        rd_start = 1'b0;
    logic [23:0] rd_addr  = '0;
    logic [8:0]  rd_len   = '0;

    always #5 clk = ~clk;

    logic [7:0] mem [4096];
    int n_vec = 0;
    int n_err = 0;

    wire        sclk_w    [2];
    wire        cs_w      [2];
    wire        mosi_w    [2];
    wire [7:0]  rd_data_w [2];
    wire        valid_w   [2];
    wire        busy_w    [2];
    wire        done_w    [2];

    wire [31:0]  m_frames   [2];
    wire [31:0]  m_cs_low   [2];
    wire [31:0]  m_rises    [2];
    wire [31:0]  m_done     [2];
    wire [31:0]  m_valid_n  [2];
    wire [31:0]  m_min_gap  [2];
    wire [31:0]  m_max_gap  [2];
    wire [31:0]  m_done_gap [2];
    wire [31:0]  m_mosi_err [2];
    wire [31:0]  m_cmd      [2];
    wire [127:0] m_rx       [2];

    // Flash with 4 KiB of storage aliased over the address space
    function automatic logic flash_bit(input logic [23:0] a, input int k);
        logic [11:0] idx;
        logic [7:0]  b;
        idx = a[11:0] + 12'(k / 8);
        b   = mem[idx];
        return b[7 - (k % 8)];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D = (g == 0) ? 2 : 1;
        logic         miso   = 1'b0;
        logic         cs_p   = 1'b1;
        logic         sclk_p = 1'b0;
        int           cyc = 0, frames = 0, cs_low = 0, rises = 0, done_n = 0, valid_n = 0;
        int           last_v = 0, min_gap = 0, max_gap = 0, done_gap = 0, mosi_err = 0;
        logic [31:0]  cmd = '0;
        logic [127:0] rx  = '0;

        spi_flash_reader #(.CLK_DIV(D), .RD_CMD(8'h03)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .rd_start (rd_start),
            .rd_addr  (rd_addr),
            .rd_len   (rd_len),
            .spi_miso (miso),
            .spi_clk  (sclk_w[g]),
            .cs       (cs_w[g]),
            .spi_mosi (mosi_w[g]),
            .rd_data  (rd_data_w[g]),
            .rd_valid (valid_w[g]),
            .rd_busy  (busy_w[g]),
            .rd_done  (done_w[g])
        );

        always @(negedge clk) begin
            cyc    <= cyc + 1;
            cs_p   <= cs_w[g];
            sclk_p <= sclk_w[g];
            if (!cs_w[g] && cs_p) begin
                frames   <= frames + 1;
                cs_low   <= 1;
                rises    <= 0;
                valid_n  <= 0;
                cmd      <= '0;
                mosi_err <= 0;
                min_gap  <= 2147483647;
                max_gap  <= 0;
            end else if (!cs_w[g]) begin
                cs_low <= cs_low + 1;
            end
            if (!cs_w[g] && sclk_w[g] && !sclk_p) begin
                rises <= rises + 1;
                if (rises < 32) cmd <= {cmd[30:0], mosi_w[g]};
                else if (mosi_w[g]) mosi_err <= mosi_err + 1;
            end
            // device shifts its next bit out after each falling SCLK; junk until the address is in
            if (!cs_w[g] && !sclk_w[g] && sclk_p) begin
                if (rises >= 32) miso <= flash_bit(cmd[23:0], rises - 32);
                else miso <= 1'($urandom_range(0, 1));
            end
            if (valid_w[g]) begin
                valid_n <= valid_n + 1;
                rx      <= {rx[119:0], rd_data_w[g]};
                last_v  <= cyc;
                if (valid_n > 0) begin
                    if (cyc - last_v < min_gap) min_gap <= cyc - last_v;
                    if (cyc - last_v > max_gap) max_gap <= cyc - last_v;
                end
            end
            if (done_w[g]) begin
                done_n   <= done_n + 1;
                done_gap <= cyc - last_v;
            end
        end

        assign m_frames[g]   = frames;
        assign m_cs_low[g]   = cs_low;
        assign m_rises[g]    = rises;
        assign m_done[g]     = done_n;
        assign m_valid_n[g]  = valid_n;
        assign m_min_gap[g]  = min_gap;
        assign m_max_gap[g]  = max_gap;
        assign m_done_gap[g] = done_gap;
        assign m_mosi_err[g] = mosi_err;
        assign m_cmd[g]      = cmd;
        assign m_rx[g]       = rx;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input logic [23:0] addr, input int len, input string tag);
        @(posedge clk); #1;
        rd_addr  = addr;
        rd_len   = 9'(len);
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        rd_addr  = 24'($urandom);
        rd_len   = 9'($urandom_range(1, 511));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s.busy_start[%0d]", tag, i), busy_w[i], 1'b1);
            chk($sformatf("%s.cs_start[%0d]", tag, i), cs_w[i], 1'b0);
        end
    endtask

    task automatic finish_txn(input logic [23:0] addr, input int len, input string tag,
                              input int f0, input int f1, input int d0, input int d1);
        int n = 0;
        int budget = 2 * (2 + 2 * (32 + 8 * len)) + 60;
        logic [127:0] exp_rx = '0;
        logic [127:0] mask;
        while ((m_done[0] != 32'(d0 + 1) || m_done[1] != 32'(d1 + 1)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".done_timeout"}, 128'(n >= budget), 128'd0);
        repeat (3) @(negedge clk);
        for (int j = 0; j < len; j++) exp_rx = {exp_rx[119:0], mem[addr[11:0] + 12'(j)]};
        mask = (len >= 16) ? '1 : ((128'd1 << (8 * len)) - 128'd1);
        for (int i = 0; i < 2; i++) begin
            int dv = (i == 0) ? 2 : 1;
            int nb = 32 + 8 * len;
            chk($sformatf("%s.frames[%0d]", tag, i), m_frames[i], 32'(((i == 0) ? f0 : f1) + 1));
            chk($sformatf("%s.done[%0d]", tag, i), m_done[i], 32'(((i == 0) ? d0 : d1) + 1));
            chk($sformatf("%s.mosi_cmd[%0d]", tag, i), m_cmd[i], {8'h03, addr});
            chk($sformatf("%s.mosi_data0[%0d]", tag, i), m_mosi_err[i], 32'd0);
            chk($sformatf("%s.cs_low[%0d]", tag, i), m_cs_low[i], 32'(dv * (2 + 2 * nb)));
            chk($sformatf("%s.sclk_rises[%0d]", tag, i), m_rises[i], 32'(nb));
            chk($sformatf("%s.valid_n[%0d]", tag, i), m_valid_n[i], 32'(len));
            chk($sformatf("%s.rx[%0d]", tag, i), m_rx[i] & mask, exp_rx);
            chk($sformatf("%s.done_after_valid[%0d]", tag, i), 128'(m_done_gap[i] >= 32'(dv + 1)), 128'd1);
            if (len >= 2) begin
                chk($sformatf("%s.min_gap[%0d]", tag, i), m_min_gap[i], 32'(16 * dv));
                chk($sformatf("%s.max_gap[%0d]", tag, i), m_max_gap[i], 32'(16 * dv));
            end
            chk($sformatf("%s.idle[%0d]", tag, i), {cs_w[i], sclk_w[i], busy_w[i]}, 3'b100);
        end
    endtask

    task automatic run_txn(input logic [23:0] addr, input int len, input string tag);
        int f0 = m_frames[0];
        int f1 = m_frames[1];
        int d0 = m_done[0];
        int d1 = m_done[1];
        start_txn(addr, len, tag);
        finish_txn(addr, len, tag, f0, f1, d0, d1);
    endtask

    initial begin
        int f0, f1, d0, d1, n, bad;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst.outs[%0d]", i),
                {sclk_w[i], cs_w[i], mosi_w[i], valid_w[i], busy_w[i], done_w[i]}, 6'b010000);
            chk($sformatf("rst.rd_data[%0d]", i), rd_data_w[i], 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;

        mem[12'h000] = 8'hA5;
        run_txn(24'h000000, 1, "t1");

        mem[12'h456] = 8'h01;
        mem[12'h457] = 8'h02;
        mem[12'h458] = 8'h03;
        mem[12'h459] = 8'h04;
        run_txn(24'h123456, 4, "t2");

        // start request while shifting must be dropped
        f0 = m_frames[0]; f1 = m_frames[1]; d0 = m_done[0]; d1 = m_done[1];
        start_txn(24'h0A0B0C, 3, "t3");
        n = 0;
        while (m_rises[0] < 32'd10 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t3.reach_shift", 128'(n < 400), 128'd1);
        @(posedge clk); #1;
        rd_addr = 24'hABCDEF; rd_len = 9'd5; rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        finish_txn(24'h0A0B0C, 3, "t3", f0, f1, d0, d1);
        repeat (20) @(negedge clk);
        chk("t3.no_second_frame", {m_frames[0], m_frames[1]}, {32'(f0 + 1), 32'(f1 + 1)});

        // zero length request
        f0 = m_frames[0]; f1 = m_frames[1]; d0 = m_done[0]; d1 = m_done[1];
        @(posedge clk); #1;
        rd_addr = 24'h111111; rd_len = 9'd0; rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (!cs_w[0] || !cs_w[1] || busy_w[0] || busy_w[1]) bad++;
        end
        chk("t4.cs_busy_quiet", bad, 0);
        chk("t4.frames", {m_frames[0], m_frames[1]}, {32'(f0), 32'(f1)});
        chk("t4.done", {m_done[0], m_done[1]}, {32'(d0), 32'(d1)});

        // reset during data bit 36 of the CLK_DIV=2 instance
        d0 = m_done[0];
        start_txn(24'h000200, 2, "t5");
        n = 0;
        while (m_rises[0] != 32'd37 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t5.reach_bit36", 128'(n < 400), 128'd1);
        rst = 1'b1;
        #1;
        chk("t5.cs_sclk_async[0]", {cs_w[0], sclk_w[0]}, 2'b10);
        chk("t5.cs_sclk_async[1]", {cs_w[1], sclk_w[1]}, 2'b10);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5.no_done", m_done[0], 32'(d0));
        chk("t5.no_valid", m_valid_n[0], 32'd0);
        chk("t5.busy_low", {busy_w[0], busy_w[1]}, 2'b00);
        run_txn(24'h000200, 2, "t5clean");

        for (int t = 0; t < 8; t++)
            run_txn(24'($urandom), $urandom_range(1, 16), $sformatf("rnd%0d", t));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
